// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   - frame bit positions of the 11-bit SIPO frame
//   - receive-controller FSM state encoding
//   - FIFO entry width and packed entry layout {ferr, perr, data}
package uart_pkg;

  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;
  localparam int FRAME_W    = 11;
  localparam int ENTRY_W    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Parameterised synchronous FIFO with show-ahead output.
// Ports:
//   baud_clk, reset_n     : clock, asynchronous active-low reset
//   push, wr_entry        : write request and data (ignored when full without a pop)
//   pop                   : read request (ignored when empty)
//   rd_entry              : head entry; holds the last popped entry while empty
//   full, empty, count    : occupancy status
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                       baud_clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_entry,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_entry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge baud_clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Storage is not reset, so the empty case shows the held copy instead.
  assign rd_entry = empty ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller between the SIPO deserialiser and the host.
// Detects each completed frame, checks start/stop/parity, queues the data
// byte with error tags into a show-ahead FIFO and keeps sticky status flags.
// Ports:
//   baud_clk, reset_n               : 16x clock, asynchronous active-low reset
//   rx_en                           : gate for new frames
//   frame_parll, frame_rdy          : SIPO frame and its received level flag
//   frame_active                    : SIPO reception in progress
//   rd_data/rd_perr/rd_ferr/rd_valid: FIFO head, drained with rd_ready
//   fifo_count                      : FIFO occupancy
//   parity_err/framing_err/overrun_err : sticky flags, cleared by clr_status
//   rx_busy                         : reception or checking in progress
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter bit DROP_BAD   = 1'b0
) (
  input  logic                       baud_clk,
  input  logic                       reset_n,
  input  logic                       rx_en,
  input  logic [FRAME_W-1:0]         frame_parll,
  input  logic                       frame_rdy,
  input  logic                       frame_active,
  output logic [7:0]                 rd_data,
  output logic                       rd_perr,
  output logic                       rd_ferr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       parity_err,
  output logic                       framing_err,
  output logic                       overrun_err,
  input  logic                       clr_status,
  output logic                       rx_busy
);

  rx_state_e          state;
  rx_state_e          next_state;
  logic               rdy_q;
  logic               rx_event;
  logic [FRAME_W-1:0] frame_q;
  logic               perr_q;
  logic               ferr_q;
  logic               latch_frame;
  logic               do_check;
  logic               push;
  logic               pop;
  logic               set_perr;
  logic               set_ferr;
  logic               set_ovr;
  logic               fifo_full;
  logic               fifo_empty;
  rx_entry_t          wr_entry;
  rx_entry_t          rd_entry;

  // frame_rdy is a 16-cycle level; only its rising edge counts as a frame.
  assign rx_event = frame_rdy & ~rdy_q;
  assign pop      = ~fifo_empty & rd_ready;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    latch_frame = 1'b0;
    do_check    = 1'b0;
    push        = 1'b0;
    set_perr    = 1'b0;
    set_ferr    = 1'b0;
    set_ovr     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_event & rx_en) begin
          latch_frame = 1'b1;
          next_state  = CHECK;
        end
      end
      CHECK: begin
        do_check   = 1'b1;
        next_state = COMMIT;
      end
      COMMIT: begin
        set_perr   = perr_q;
        set_ferr   = ferr_q;
        next_state = IDLE;
        // Error flags are raised even when a bad frame is discarded.
        if (!((perr_q | ferr_q) & DROP_BAD)) begin
          if (fifo_full & ~pop) set_ovr = 1'b1;
          else                  push    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q       <= 1'b0;
      frame_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rdy_q <= frame_rdy;
      if (latch_frame) frame_q <= frame_parll;
      if (do_check) begin
        // XOR across data and parity bit is 0 for a correct even-parity frame.
        perr_q <= PARITY_EN & ((^frame_q[PARITY_BIT:DATA_LSB]) != PARITY_ODD);
        ferr_q <= frame_q[START_BIT] | ~frame_q[STOP_BIT];
      end
      // A set in the same cycle as clr_status wins.
      parity_err  <= set_perr | (parity_err  & ~clr_status);
      framing_err <= set_ferr | (framing_err & ~clr_status);
      overrun_err <= set_ovr  | (overrun_err & ~clr_status);
    end
  end

  assign wr_entry = '{ferr: ferr_q, perr: perr_q, data: frame_q[DATA_MSB:DATA_LSB]};

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rd_data  = rd_entry.data;
  assign rd_perr  = rd_entry.perr;
  assign rd_ferr  = rd_entry.ferr;
  assign rd_valid = ~fifo_empty;
  // Gated by reset so the output reads 0 while reset is held.
  assign rx_busy  = reset_n & (frame_active | (state != IDLE));

endmodule
